// File: rtl/ecc_fifo_pkg.sv
// Shared sizing helpers for the ECC-encoded FIFO store.
// Stored words carry 12 bits per payload byte (8 data + 4 check).
package ecc_fifo_pkg;

  localparam int BYTE_ENC_WIDTH = 12;

  function automatic int enc_width(input int data_width);
    return data_width + (data_width / 8) * (BYTE_ENC_WIDTH - 8);
  endfunction

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_store_ptr.sv
// Wrapping ADDR_WIDTH-bit address pointer with synchronous active-high reset.
// The wrap from all-ones back to zero falls out of the natural modulo add.
module fifo_store_ptr #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  IncEn,
  output logic [ADDR_WIDTH-1:0] Ptr
);

  always_ff @(posedge Clock) begin
    if (Reset)      Ptr <= '0;
    else if (IncEn) Ptr <= Ptr + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/ecc_fifo_store.sv
// Single-clock FIFO buffering ECC-encoded words, with active-low registered flags.
// Define FIFO_ERR_INJECT_EN to add InjectEn/InjectMask for corrupting stored words.
module ecc_fifo_store
  import ecc_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  localparam int ENC_WIDTH  = enc_width(DATA_WIDTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEn,
  input  logic                  ReadEn,
  input  logic [ENC_WIDTH-1:0]  DataInEnc,
`ifdef FIFO_ERR_INJECT_EN
  input  logic                  InjectEn,
  input  logic [ENC_WIDTH-1:0]  InjectMask,
`endif
  output logic [ENC_WIDTH-1:0]  DataOutEnc,
  output logic                  Empty_,
  output logic                  HalfFull_,
  output logic                  Full_,
  output logic [ADDR_WIDTH-1:0] WritePtr,
  output logic [ADDR_WIDTH-1:0] ReadPtr
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ENC_WIDTH-1:0] mem [DEPTH];
  logic [ENC_WIDTH-1:0] wrWord;
  logic [CW-1:0]        count;
  logic [CW-1:0]        nextCount;
  logic                 doWrite;
  logic                 doRead;

  // Qualify from the registered flags so a full/empty FIFO never over/underruns.
  assign doWrite = WriteEn & Full_;
  assign doRead  = ReadEn  & Empty_;

`ifdef FIFO_ERR_INJECT_EN
  assign wrWord = InjectEn ? (DataInEnc ^ InjectMask) : DataInEnc;
`else
  assign wrWord = DataInEnc;
`endif

  fifo_store_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) uWrPtr (
    .Clock (Clock),
    .Reset (Reset),
    .IncEn (doWrite),
    .Ptr   (WritePtr)
  );

  fifo_store_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) uRdPtr (
    .Clock (Clock),
    .Reset (Reset),
    .IncEn (doRead),
    .Ptr   (ReadPtr)
  );

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (!Reset && doWrite) mem[WritePtr] <= wrWord;
  end

  always_ff @(posedge Clock) begin
    if (Reset)       DataOutEnc <= '0;
    else if (doRead) DataOutEnc <= mem[ReadPtr];
  end

  always_comb begin
    nextCount = count;
    case ({doWrite, doRead})
      2'b10:   nextCount = count + CW'(1);
      2'b01:   nextCount = count - CW'(1);
      default: nextCount = count;
    endcase
  end

  // Flags come from next-count so they line up with the pointers each cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count     <= '0;
      Empty_    <= 1'b0;
      HalfFull_ <= 1'b1;
      Full_     <= 1'b1;
    end else begin
      count     <= nextCount;
      Empty_    <= (nextCount != '0);
      HalfFull_ <= (nextCount <  CW'(DEPTH / 2));
      Full_     <= (nextCount != CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ecc_fifo_store.sv
// Directed self-checking bench for ecc_fifo_store (DEPTH=256, ENC_WIDTH=48).
// Covers reset, single word, half/full boundaries, empty R+W, wrap, inject.
module tb_ecc_fifo_store;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WriteEn;
  logic        ReadEn;
  logic [47:0] DataInEnc;
  logic [47:0] DataOutEnc;
  logic        Empty_, HalfFull_, Full_;
  logic [7:0]  WritePtr, ReadPtr;
`ifdef FIFO_ERR_INJECT_EN
  logic        InjectEn;
  logic [47:0] InjectMask;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 Clock = ~Clock;

  ecc_fifo_store dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WriteEn    (WriteEn),
    .ReadEn     (ReadEn),
    .DataInEnc  (DataInEnc),
`ifdef FIFO_ERR_INJECT_EN
    .InjectEn   (InjectEn),
    .InjectMask (InjectMask),
`endif
    .DataOutEnc (DataOutEnc),
    .Empty_     (Empty_),
    .HalfFull_  (HalfFull_),
    .Full_      (Full_),
    .WritePtr   (WritePtr),
    .ReadPtr    (ReadPtr)
  );

  function automatic logic [47:0] word(input int i);
    return {16'hC0DE, 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests, sampled 1ns after the edge.
  task automatic cyc(input logic we, input logic re, input logic [47:0] d);
    WriteEn = we; ReadEn = re; DataInEnc = d;
    @(posedge Clock); #1;
    WriteEn = 1'b0; ReadEn = 1'b0;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; WriteEn = 1'b0; ReadEn = 1'b0; DataInEnc = '0;
`ifdef FIFO_ERR_INJECT_EN
    InjectEn = 1'b0; InjectMask = '0;
`endif
    doReset();
    chk("rst_wptr", 64'(WritePtr), 64'd0);
    chk("rst_rptr", 64'(ReadPtr), 64'd0);
    chk("rst_empty", 64'(Empty_), 64'd0);
    chk("rst_half", 64'(HalfFull_), 64'd1);
    chk("rst_full", 64'(Full_), 64'd1);
    chk("rst_dout", 64'(DataOutEnc), 64'd0);

    // Single word round trip
    cyc(1'b1, 1'b0, 48'h0123_4567_89AB);
    chk("w1_empty", 64'(Empty_), 64'd1);
    chk("w1_wptr", 64'(WritePtr), 64'd1);
    cyc(1'b0, 1'b1, '0);
    chk("r1_dout", 64'(DataOutEnc), 64'h0123_4567_89AB);
    chk("r1_empty", 64'(Empty_), 64'd0);
    chk("r1_rptr", 64'(ReadPtr), 64'd1);

    // Half-full boundary
    doReset();
    for (int i = 0; i < 127; i++) cyc(1'b1, 1'b0, word(i));
    chk("hf_127", 64'(HalfFull_), 64'd1);
    cyc(1'b1, 1'b0, word(127));
    chk("hf_128", 64'(HalfFull_), 64'd0);
    chk("hf_128_wptr", 64'(WritePtr), 64'd128);
    cyc(1'b0, 1'b1, '0);
    chk("hf_rd_half", 64'(HalfFull_), 64'd1);
    chk("hf_rd_dout", 64'(DataOutEnc), 64'(word(0)));

    // Full boundary, dropped write, R+W while full
    doReset();
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b0, word(i));
    chk("f_255_full", 64'(Full_), 64'd1);
    cyc(1'b1, 1'b0, word(255));
    chk("f_256_full", 64'(Full_), 64'd0);
    chk("f_256_wptr", 64'(WritePtr), 64'd0);
    chk("f_256_empty", 64'(Empty_), 64'd1);
    cyc(1'b1, 1'b0, 48'hDEAD_BEEF_0000);
    chk("f_drop_wptr", 64'(WritePtr), 64'd0);
    chk("f_drop_full", 64'(Full_), 64'd0);
    cyc(1'b1, 1'b1, 48'hDEAD_BEEF_0001);
    chk("f_rw_full", 64'(Full_), 64'd1);
    chk("f_rw_wptr", 64'(WritePtr), 64'd0);
    chk("f_rw_rptr", 64'(ReadPtr), 64'd1);
    chk("f_rw_dout", 64'(DataOutEnc), 64'(word(0)));
    chk("f_rw_half", 64'(HalfFull_), 64'd0);
    cyc(1'b1, 1'b0, word(256));
    chk("f_refill_full", 64'(Full_), 64'd0);
    chk("f_refill_wptr", 64'(WritePtr), 64'd1);
    cyc(1'b0, 1'b1, '0);
    chk("f_drop_data", 64'(DataOutEnc), 64'(word(1)));

    // Empty with R+W: only the write happens
    doReset();
    cyc(1'b1, 1'b1, 48'hABCD_0000_1111);
    chk("e_rw_empty", 64'(Empty_), 64'd1);
    chk("e_rw_wptr", 64'(WritePtr), 64'd1);
    chk("e_rw_rptr", 64'(ReadPtr), 64'd0);
    chk("e_rw_dout", 64'(DataOutEnc), 64'd0);
    cyc(1'b0, 1'b1, '0);
    chk("e_rd_dout", 64'(DataOutEnc), 64'hABCD_0000_1111);
    chk("e_rd_empty", 64'(Empty_), 64'd0);

    // 300 words streamed through, pointers wrap to 44
    doReset();
    cyc(1'b1, 1'b0, word(1000));
    for (int i = 1; i < 300; i++) begin
      cyc(1'b1, 1'b1, word(1000 + i));
      chk("s_data", 64'(DataOutEnc), 64'(word(1000 + i - 1)));
    end
    cyc(1'b0, 1'b1, '0);
    chk("s_last", 64'(DataOutEnc), 64'(word(1299)));
    chk("s_wptr", 64'(WritePtr), 64'd44);
    chk("s_rptr", 64'(ReadPtr), 64'd44);
    chk("s_empty", 64'(Empty_), 64'd0);
    cyc(1'b0, 1'b1, '0);
    chk("s_uflow_dout", 64'(DataOutEnc), 64'(word(1299)));
    chk("s_uflow_rptr", 64'(ReadPtr), 64'd44);

    // Reset mid-operation overrides a concurrent write
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, word(i));
    chk("m_wptr_pre", 64'(WritePtr), 64'd54);
    WriteEn = 1'b1; ReadEn = 1'b1; DataInEnc = 48'h1;
    doReset();
    WriteEn = 1'b0; ReadEn = 1'b0;
    chk("m_wptr", 64'(WritePtr), 64'd0);
    chk("m_rptr", 64'(ReadPtr), 64'd0);
    chk("m_empty", 64'(Empty_), 64'd0);
    chk("m_dout", 64'(DataOutEnc), 64'd0);
    chk("m_half", 64'(HalfFull_), 64'd1);

`ifdef FIFO_ERR_INJECT_EN
    InjectEn = 1'b1; InjectMask = 48'h1;
    cyc(1'b1, 1'b0, 48'h0123_4567_89AB);
    InjectEn = 1'b0; InjectMask = '0;
    chk("inj_wptr", 64'(WritePtr), 64'd1);
    cyc(1'b0, 1'b1, '0);
    chk("inj_dout", 64'(DataOutEnc), 64'h0123_4567_89AA);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
